ahblite_bus_matrix_decoder: RTL and testbench
=============================================

Name: ahblite_bus_matrix_decoder

Overview:
Parametrised AHB-Lite address decoder plus data-phase response multiplexer for the single-master Cortex-M0 bus. It is configurable in port count, per-port base/mask and per-port enable. It also contains a built-in default slave that returns the two-cycle ERROR response for unmapped active transfers. It sits between the CM0 master and the slave ports (RAMCODE, RAMDATA, AHB/APB bridges) and drives HSEL, HREADY, HRESP and HRDATA back to the master.

Parameters:
NPORT, 4, number of slave ports (1..16)
BASE_ADDR, {32'h5000_0000,32'h4000_0000,32'h2000_0000,32'h0000_0000}, packed NPORT*32; port i base in bits [32i+31:32i]
ADDR_MASK, {4{32'hFFFF_0000}}, packed NPORT*32; port i hits when (HADDR & mask_i) == (base_i & mask_i)
PORT_EN, 4'b1111, per-port enable; disabled port never selected, its range falls to default slave

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  asynchronous active-low reset
HADDR  in  32  address-phase address from master
HTRANS  in  2  transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
HSEL  out  NPORT  address-phase one-hot slave select (combinational)
HREADYOUT_S  in  NPORT  per-slave HREADYOUT
HRESP_S  in  NPORT  per-slave HRESP
HRDATA_S  in  NPORT*32  per-slave read data, port i at [32i+31:32i]
HREADY  out  1  muxed ready to master and all slaves
HRESP  out  1  muxed response to master
HRDATA  out  32  muxed read data to master

Behaviour:
- Address decode is combinational. hit_i = PORT_EN[i] && ((HADDR & ADDR_MASK_i) == (BASE_ADDR_i & ADDR_MASK_i)).
- Overlapping ranges: the lowest index wins, so HSEL is always one-hot or zero.
- HSEL is driven regardless of HTRANS; slaves qualify it with HTRANS and HREADY themselves.
- Data-phase select register dsel_q (NPORT+1 states: port 0..NPORT-1, DEFAULT):
  - Loaded only when HREADY==1; holds while HREADY==0 (wait states).
  - Loads the winning port index; if there is no hit, it loads DEFAULT.
  - Reset value is DEFAULT.
- Output mux:
  - dsel_q = port i: HREADY=HREADYOUT_S[i], HRESP=HRESP_S[i], HRDATA=HRDATA_S[i].
  - dsel_q = DEFAULT: outputs come from the default slave; HRDATA=32'h0.
- Default slave FSM, states IDLE, ERR1, ERR2:
  - IDLE: HREADY=1, HRESP=0. Moves to ERR1 when HREADY==1, there is no hit, and HTRANS[1]==1 (NONSEQ/SEQ).
  - ERR1: HREADY=0, HRESP=1. Always moves to ERR2 on the next cycle.
  - ERR2: HREADY=1, HRESP=1. Moves to ERR1 if another unmapped NONSEQ/SEQ is sampled this cycle; otherwise moves to IDLE.
  - Unmapped IDLE/BUSY transfers give a zero-wait OKAY (FSM stays IDLE).
- Reset: all outputs are asserted immediately on HRESETn low, independent of HCLK: HREADY=1, HRESP=0, HRDATA=0, FSM=IDLE, dsel_q=DEFAULT. A reset in mid-transfer (including during ERR1) aborts to these values with no residual state.
- Back-to-back transfers:
  - Mapped-after-error: the address phase sampled in ERR2 (HREADY=1) updates dsel_q, so the next data phase is served by the new slave.
  - Error-after-mapped: dsel_q switches to DEFAULT at the same HREADY edge the FSM enters ERR1.
- A slave wait state stalls dsel_q. The default FSM does not advance out of IDLE while HREADY==0.
- Throughput is unchanged versus a plain decoder: zero added latency on mapped paths.

Decomposition:
- Shared package ahb_pkg: HTRANS encodings (HTRANS_IDLE/BUSY/NONSEQ/SEQ), HRESP_OKAY=0 / HRESP_ERROR=1, default memory map constants (RAMCODE/RAMDATA/AHB/APB base and mask).
- One sub-module, ahblite_default_slave: holds the IDLE/ERR1/ERR2 FSM. Inputs are HCLK, HRESETn, sel (no-hit), HTRANS, HREADY; outputs are HREADYOUT and HRESP.
- The decoder/mux stays in the top level.

Test Plan:
- Reset: hold HRESETn=0 with HTRANS=NONSEQ, HADDR=0x2000_0010 -> HREADY=1, HRESP=0, HRDATA=0; HSEL=4'b0010 (combinational).
- Mapped read: NONSEQ to 0x4000_0004; next cycle port2 returns HREADYOUT_S[2]=1, HRDATA_S[2]=0xDEAD_BEEF -> HSEL=4'b0100 in the address phase; HRDATA=0xDEAD_BEEF, HRESP=0 in the data phase.
- Wait states: NONSEQ to 0x0000_0100; port0 HREADYOUT low for 3 cycles while HADDR changes to 0x5000_0000 -> HREADY=0 for 3 cycles; data still from port0; dsel_q moves to port3 only on the HREADY=1 edge.
- Unmapped error: NONSEQ to 0x6000_0000 -> next cycle HREADY=0/HRESP=1, following cycle HREADY=1/HRESP=1, then IDLE; HRDATA=0. The same address with HTRANS=IDLE -> OKAY, zero waits.
- Back-to-back errors and disable: build with PORT_EN=4'b1011; NONSEQ 0x4000_0000 then SEQ 0x4000_0004 -> two full ERR1/ERR2 sequences with no IDLE cycle between; HSEL[2] stays 0.
- Overlap and reset mid-error: BASE0=BASE1=0x2000_0000 -> only HSEL[0]=1. Assert HRESETn=0 during ERR1 -> HREADY=1, HRESP=0 asynchronously.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, default-slave state type and the Cortex-M0 memory map.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  localparam logic [31:0] RAMCODE_BASE = 32'h0000_0000;
  localparam logic [31:0] RAMDATA_BASE = 32'h2000_0000;
  localparam logic [31:0] AHB_BASE     = 32'h4000_0000;
  localparam logic [31:0] APB_BASE     = 32'h5000_0000;
  localparam logic [31:0] RAMCODE_MASK = 32'hFFFF_0000;
  localparam logic [31:0] RAMDATA_MASK = 32'hFFFF_0000;
  localparam logic [31:0] AHB_MASK     = 32'hFFFF_0000;
  localparam logic [31:0] APB_MASK     = 32'hFFFF_0000;

endpackage

// File: rtl/ahblite_bus_matrix_decoder_if.sv
// Master-side address phase plus per-slave responses and the muxed return path.
interface ahblite_bus_matrix_decoder_if #(
  parameter int unsigned NPORT = 4
);
  logic [31:0]         HADDR;
  logic [1:0]          HTRANS;
  logic [NPORT-1:0]    HSEL;
  logic [NPORT-1:0]    HREADYOUT_S;
  logic [NPORT-1:0]    HRESP_S;
  logic [NPORT*32-1:0] HRDATA_S;
  logic                HREADY;
  logic                HRESP;
  logic [31:0]         HRDATA;

  // Fabric side: master address phase and slave responses are driven into the decoder.
  modport master (
    output HADDR, HTRANS, HREADYOUT_S, HRESP_S, HRDATA_S,
    input  HSEL, HREADY, HRESP, HRDATA
  );

  modport slave (
    input  HADDR, HTRANS, HREADYOUT_S, HRESP_S, HRDATA_S,
    output HSEL, HREADY, HRESP, HRDATA
  );
endinterface

// File: rtl/ahblite_bus_matrix_decoder_default_slave.sv
// Default slave: two-cycle ERROR response for active transfers that hit no port.
module ahblite_default_slave
  import ahb_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       sel,
  input  logic [1:0] HTRANS,
  input  logic       HREADY,
  output logic       HREADYOUT,
  output logic       HRESP
);

  ds_state_e state_q, state_d;
  logic      active;

  assign active = HREADY && sel &&
                  ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= DS_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    case (state_q)
      DS_IDLE: if (active) state_d = DS_ERR1;
      DS_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_d   = DS_ERR2;
      end
      DS_ERR2: begin
        HRESP   = HRESP_ERROR;
        state_d = active ? DS_ERR1 : DS_IDLE;
      end
      default: state_d = DS_IDLE;
    endcase
  end

endmodule

// File: rtl/ahblite_bus_matrix_decoder.sv
// AHB-Lite address decoder with data-phase response mux and built-in default slave.
module ahblite_bus_matrix_decoder
  import ahb_pkg::*;
#(
  parameter int unsigned         NPORT     = 4,
  parameter logic [NPORT*32-1:0] BASE_ADDR = {APB_BASE, AHB_BASE, RAMDATA_BASE, RAMCODE_BASE},
  parameter logic [NPORT*32-1:0] ADDR_MASK = {APB_MASK, AHB_MASK, RAMDATA_MASK, RAMCODE_MASK},
  parameter logic [NPORT-1:0]    PORT_EN   = '1
) (
  input logic                    HCLK,
  input logic                    HRESETn,
  ahblite_bus_matrix_decoder_if.slave bus
);

  // Data-phase select index; value NPORT denotes the default slave.
  localparam int unsigned DW = $clog2(NPORT + 1);
  localparam logic [DW-1:0] DSEL_DEFAULT = DW'(NPORT);

  logic [NPORT-1:0] hsel;
  logic             hit_any;
  logic [DW-1:0]    win_idx;
  logic [DW-1:0]    dsel_q;
  logic             ds_hready;
  logic             ds_hresp;
  logic             hready;
  logic             hresp;
  logic [31:0]      hrdata;

  // First hit in index order wins, keeping HSEL one-hot on overlapping ranges.
  always_comb begin
    hsel    = '0;
    hit_any = 1'b0;
    win_idx = DSEL_DEFAULT;
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (!hit_any && PORT_EN[i] &&
          ((bus.HADDR & ADDR_MASK[32*i +: 32]) == (BASE_ADDR[32*i +: 32] & ADDR_MASK[32*i +: 32]))) begin
        hit_any = 1'b1;
        hsel[i] = 1'b1;
        win_idx = DW'(i);
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)    dsel_q <= DSEL_DEFAULT;
    else if (hready) dsel_q <= win_idx;
  end

  ahblite_default_slave u_default_slave (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .sel       (!hit_any),
    .HTRANS    (bus.HTRANS),
    .HREADY    (hready),
    .HREADYOUT (ds_hready),
    .HRESP     (ds_hresp)
  );

  always_comb begin
    hready = ds_hready;
    hresp  = ds_hresp;
    hrdata = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (dsel_q == DW'(i)) begin
        hready = bus.HREADYOUT_S[i];
        hresp  = bus.HRESP_S[i];
        hrdata = bus.HRDATA_S[32*i +: 32];
      end
    end
  end

  assign bus.HSEL   = hsel;
  assign bus.HREADY = hready;
  assign bus.HRESP  = hresp;
  assign bus.HRDATA = hrdata;

endmodule

// File: tb/tb_ahblite_bus_matrix_decoder.sv
// Directed bench: default map, a build with port 2 disabled, and a build with overlapping ports 0/1.
module tb_ahblite_bus_matrix_decoder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  haddr = '0;
  logic [1:0]   htrans = 2'b00;
  logic [3:0]   rdy_s = 4'hF;
  logic [3:0]   resp_s = 4'h0;
  logic [127:0] rdata_s = '0;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  ahblite_bus_matrix_decoder_if #(.NPORT(4)) bus_a ();
  ahblite_bus_matrix_decoder_if #(.NPORT(4)) bus_b ();
  ahblite_bus_matrix_decoder_if #(.NPORT(4)) bus_c ();

  assign bus_a.HADDR = haddr;  assign bus_a.HTRANS = htrans;
  assign bus_a.HREADYOUT_S = rdy_s;  assign bus_a.HRESP_S = resp_s;  assign bus_a.HRDATA_S = rdata_s;
  assign bus_b.HADDR = haddr;  assign bus_b.HTRANS = htrans;
  assign bus_b.HREADYOUT_S = rdy_s;  assign bus_b.HRESP_S = resp_s;  assign bus_b.HRDATA_S = rdata_s;
  assign bus_c.HADDR = haddr;  assign bus_c.HTRANS = htrans;
  assign bus_c.HREADYOUT_S = rdy_s;  assign bus_c.HRESP_S = resp_s;  assign bus_c.HRDATA_S = rdata_s;

  ahblite_bus_matrix_decoder #(.NPORT(4)) dut_a (
    .HCLK(clk), .HRESETn(rst_n), .bus(bus_a)
  );

  ahblite_bus_matrix_decoder #(.NPORT(4), .PORT_EN(4'b1011)) dut_b (
    .HCLK(clk), .HRESETn(rst_n), .bus(bus_b)
  );

  ahblite_bus_matrix_decoder #(
    .NPORT(4),
    .BASE_ADDR({32'h5000_0000, 32'h4000_0000, 32'h2000_0000, 32'h2000_0000})
  ) dut_c (
    .HCLK(clk), .HRESETn(rst_n), .bus(bus_c)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; htrans = 2'b10; haddr = 32'h2000_0010;
    #2;
    n_cmp++; if (bus_a.HREADY !== 1'b1) begin n_err++; $display("FAIL reset_hready: got %b expected 1", bus_a.HREADY); end
    n_cmp++; if (bus_a.HRESP !== 1'b0) begin n_err++; $display("FAIL reset_hresp: got %b expected 0", bus_a.HRESP); end
    n_cmp++; if (bus_a.HRDATA !== 32'h0) begin n_err++; $display("FAIL reset_hrdata: got %h expected 00000000", bus_a.HRDATA); end
    n_cmp++; if (bus_a.HSEL !== 4'b0010) begin n_err++; $display("FAIL reset_hsel: got %b expected 0010", bus_a.HSEL); end
    step(); step();
    n_cmp++; if (bus_a.HREADY !== 1'b1 || bus_a.HRESP !== 1'b0) begin n_err++; $display("FAIL reset_held: got %b/%b expected 1/0", bus_a.HREADY, bus_a.HRESP); end
    htrans = 2'b00; haddr = 32'h0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_mapped_read();
    step(); haddr = 32'h4000_0004; htrans = 2'b10; #1;
    n_cmp++; if (bus_a.HSEL !== 4'b0100) begin n_err++; $display("FAIL rd_hsel: got %b expected 0100", bus_a.HSEL); end
    step(); haddr = 32'h0; htrans = 2'b00; rdy_s = 4'hF; rdata_s[64 +: 32] = 32'hDEAD_BEEF; #1;
    n_cmp++; if (bus_a.HRDATA !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_hrdata: got %h expected deadbeef", bus_a.HRDATA); end
    n_cmp++; if (bus_a.HRESP !== 1'b0 || bus_a.HREADY !== 1'b1) begin n_err++; $display("FAIL rd_resp: got %b/%b expected 1/0", bus_a.HREADY, bus_a.HRESP); end
  endtask

  task automatic test_wait_states();
    step(); haddr = 32'h0000_0100; htrans = 2'b10; #1;
    n_cmp++; if (bus_a.HSEL !== 4'b0001) begin n_err++; $display("FAIL ws_hsel0: got %b expected 0001", bus_a.HSEL); end
    step(); haddr = 32'h5000_0000; rdy_s[0] = 1'b0;
    rdata_s[0 +: 32] = 32'h1111_0000; rdata_s[96 +: 32] = 32'h3333_3333; #1;
    n_cmp++; if (bus_a.HSEL !== 4'b1000) begin n_err++; $display("FAIL ws_hsel3: got %b expected 1000", bus_a.HSEL); end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin step(); #1; end
      n_cmp++; if (bus_a.HREADY !== 1'b0) begin n_err++; $display("FAIL ws_wait%0d: got %b expected 0", k, bus_a.HREADY); end
      n_cmp++; if (bus_a.HRDATA !== 32'h1111_0000) begin n_err++; $display("FAIL ws_data%0d: got %h expected 11110000", k, bus_a.HRDATA); end
    end
    step(); rdy_s[0] = 1'b1; #1;
    n_cmp++; if (bus_a.HREADY !== 1'b1 || bus_a.HRDATA !== 32'h1111_0000) begin n_err++; $display("FAIL ws_done: got %b/%h expected 1/11110000", bus_a.HREADY, bus_a.HRDATA); end
    step(); haddr = 32'h0; htrans = 2'b00; #1;
    n_cmp++; if (bus_a.HRDATA !== 32'h3333_3333) begin n_err++; $display("FAIL ws_port3: got %h expected 33333333", bus_a.HRDATA); end
  endtask

  task automatic test_unmapped_error();
    step(); haddr = 32'h6000_0000; htrans = 2'b10; #1;
    n_cmp++; if (bus_a.HSEL !== 4'b0000) begin n_err++; $display("FAIL err_hsel: got %b expected 0000", bus_a.HSEL); end
    step(); haddr = 32'h6000_0000; htrans = 2'b00; #1;
    n_cmp++; if (bus_a.HREADY !== 1'b0 || bus_a.HRESP !== 1'b1) begin n_err++; $display("FAIL err1: got %b/%b expected 0/1", bus_a.HREADY, bus_a.HRESP); end
    n_cmp++; if (bus_a.HRDATA !== 32'h0) begin n_err++; $display("FAIL err_hrdata: got %h expected 00000000", bus_a.HRDATA); end
    step(); #1;
    n_cmp++; if (bus_a.HREADY !== 1'b1 || bus_a.HRESP !== 1'b1) begin n_err++; $display("FAIL err2: got %b/%b expected 1/1", bus_a.HREADY, bus_a.HRESP); end
    for (int k = 0; k < 2; k++) begin
      step(); #1;
      n_cmp++; if (bus_a.HREADY !== 1'b1 || bus_a.HRESP !== 1'b0) begin n_err++; $display("FAIL err_idle_okay%0d: got %b/%b expected 1/0", k, bus_a.HREADY, bus_a.HRESP); end
    end
  endtask

  task automatic test_back_to_back();
    step(); haddr = 32'h4000_0000; htrans = 2'b10; #1;
    n_cmp++; if (bus_b.HSEL !== 4'b0000) begin n_err++; $display("FAIL b2b_hsel_dis: got %b expected 0000", bus_b.HSEL); end
    step(); haddr = 32'h4000_0004; htrans = 2'b11; #1;
    n_cmp++; if (bus_b.HREADY !== 1'b0 || bus_b.HRESP !== 1'b1) begin n_err++; $display("FAIL b2b_a_err1: got %b/%b expected 0/1", bus_b.HREADY, bus_b.HRESP); end
    n_cmp++; if (bus_b.HSEL[2] !== 1'b0) begin n_err++; $display("FAIL b2b_hsel2: got %b expected 0", bus_b.HSEL[2]); end
    step(); #1;
    n_cmp++; if (bus_b.HREADY !== 1'b1 || bus_b.HRESP !== 1'b1) begin n_err++; $display("FAIL b2b_a_err2: got %b/%b expected 1/1", bus_b.HREADY, bus_b.HRESP); end
    step(); haddr = 32'h0; htrans = 2'b00; #1;
    n_cmp++; if (bus_b.HREADY !== 1'b0 || bus_b.HRESP !== 1'b1) begin n_err++; $display("FAIL b2b_b_err1: got %b/%b expected 0/1", bus_b.HREADY, bus_b.HRESP); end
    step(); #1;
    n_cmp++; if (bus_b.HREADY !== 1'b1 || bus_b.HRESP !== 1'b1) begin n_err++; $display("FAIL b2b_b_err2: got %b/%b expected 1/1", bus_b.HREADY, bus_b.HRESP); end
    rdata_s[0 +: 32] = 32'h0BAD_F00D;
    step(); #1;
    n_cmp++; if (bus_b.HREADY !== 1'b1 || bus_b.HRESP !== 1'b0 || bus_b.HRDATA !== 32'h0BAD_F00D) begin n_err++; $display("FAIL b2b_mapped_after: got %b/%b/%h expected 1/0/0badf00d", bus_b.HREADY, bus_b.HRESP, bus_b.HRDATA); end
  endtask

  task automatic test_overlap_and_reset();
    step(); haddr = 32'h2000_0040; htrans = 2'b00; #1;
    n_cmp++; if (bus_c.HSEL !== 4'b0001) begin n_err++; $display("FAIL ovl_hsel: got %b expected 0001", bus_c.HSEL); end
    n_cmp++; if (bus_a.HSEL !== 4'b0010) begin n_err++; $display("FAIL ovl_ref_hsel: got %b expected 0010", bus_a.HSEL); end
    step(); haddr = 32'h6000_0000; htrans = 2'b10; #1;
    step(); htrans = 2'b00; #1;
    n_cmp++; if (bus_a.HREADY !== 1'b0 || bus_a.HRESP !== 1'b1) begin n_err++; $display("FAIL rst_pre_err1: got %b/%b expected 0/1", bus_a.HREADY, bus_a.HRESP); end
    rst_n = 1'b0; #1;
    n_cmp++; if (bus_a.HREADY !== 1'b1 || bus_a.HRESP !== 1'b0 || bus_a.HRDATA !== 32'h0) begin n_err++; $display("FAIL rst_async: got %b/%b/%h expected 1/0/00000000", bus_a.HREADY, bus_a.HRESP, bus_a.HRDATA); end
    #2 rst_n = 1'b1;
    step(); #1;
    n_cmp++; if (bus_a.HREADY !== 1'b1 || bus_a.HRESP !== 1'b0) begin n_err++; $display("FAIL rst_no_residue: got %b/%b expected 1/0", bus_a.HREADY, bus_a.HRESP); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_mapped_read();
    test_wait_states();
    test_unmapped_error();
    test_back_to_back();
    test_overlap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
